gbm_path_sequencer: RTL and testbench

- Per-lane controller that sits directly upstream of the GBM step stage and also consumes its output.
- Accepts a path start price S0 and draws one normal sample z per time step.
- Issues one step at a time to the GBM stage, then feeds each S_next back in as the next S.
- Emits every step price as an indexed stream for the downstream regression/payoff buffer.

---
 rtl/gbm_path_sequencer_pkg.sv | 14 +
 rtl/gbm_path_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_gbm_path_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gbm_path_sequencer_pkg.sv
// gbm_path_sequencer_pkg: shared fixed-point config, FSM states and sizing helper for the path sequencer
package gbm_path_sequencer_pkg;

    localparam int FP_WIDTH  = 32;
    localparam int FP_QFRAC  = 16;
    localparam int MIN_PRICE = 1;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, EMIT} gps_state_t;

    function automatic int step_w(input int n_steps);
        return $clog2(n_steps + 1);
    endfunction

endpackage

// File: rtl/gbm_path_sequencer.sv
// gbm_path_sequencer: per-lane serial GBM path walker feeding each step result back as the next start price
module gbm_path_sequencer
    import gbm_path_sequencer_pkg::*;
#(
    parameter int WIDTH   = FP_WIDTH,
    parameter int QFRAC   = FP_QFRAC,
    parameter int N_STEPS = 64,
    parameter int PATH_W  = 16,
    parameter int LANE_ID = 0,
    localparam int STEP_W = step_w(N_STEPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WIDTH-1:0]  S0,
    input  logic [WIDTH-1:0]  r,
    input  logic [WIDTH-1:0]  sigma,
    input  logic [WIDTH-1:0]  dt,
    input  logic              z_valid,
    output logic              z_ready,
    input  logic [WIDTH-1:0]  z,
    output logic              gbm_valid,
    input  logic              gbm_ready,
    output logic [WIDTH-1:0]  gbm_z,
    output logic [WIDTH-1:0]  gbm_S,
    output logic [WIDTH-1:0]  gbm_r,
    output logic [WIDTH-1:0]  gbm_sigma,
    output logic [WIDTH-1:0]  gbm_dt,
    input  logic              gbm_res_valid,
    output logic              gbm_res_ready,
    input  logic [WIDTH-1:0]  gbm_S_next,
    output logic              price_valid,
    input  logic              price_ready,
    output logic [WIDTH-1:0]  price,
    output logic [STEP_W-1:0] step_idx,
    output logic [PATH_W-1:0] path_idx,
    output logic              path_last,
    output logic              busy
);

    if (N_STEPS < 1 || QFRAC >= WIDTH || LANE_ID < 0) begin : g_param_check
        $error("gbm_path_sequencer: invalid parameters");
    end

    gps_state_t        state_q, state_d;
    logic [WIDTH-1:0]  s_cur_q, s_cur_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH-1:0]  gbm_z_q, gbm_z_d;
    logic [WIDTH-1:0]  gbm_s_q, gbm_s_d;
    logic [WIDTH-1:0]  gbm_r_q, gbm_r_d;
    logic [WIDTH-1:0]  gbm_sigma_q, gbm_sigma_d;
    logic [WIDTH-1:0]  gbm_dt_q, gbm_dt_d;
    logic [WIDTH-1:0]  price_q, price_d;
    logic [STEP_W-1:0] step_idx_q, step_idx_d;
    logic [PATH_W-1:0] path_idx_q, path_idx_d;
    logic              path_last_q, path_last_d;
    logic              price_valid_q, price_valid_d;
    logic [WIDTH-1:0]  s_clamped;
    logic [STEP_W-1:0] step_next;

    // Non-positive prices are pinned to one LSB so the log-normal walk never goes through zero
    assign s_clamped = (gbm_S_next[WIDTH-1] || gbm_S_next == '0) ? WIDTH'(MIN_PRICE) : gbm_S_next;
    assign step_next = step_q + 1'b1;

    assign start_ready   = (state_q == IDLE);
    assign z_ready       = (state_q == FETCH);
    assign gbm_valid     = (state_q == ISSUE);
    assign gbm_res_ready = (state_q == WAIT);
    assign busy          = (state_q != IDLE);
    assign gbm_z         = gbm_z_q;
    assign gbm_S         = gbm_s_q;
    assign gbm_r         = gbm_r_q;
    assign gbm_sigma     = gbm_sigma_q;
    assign gbm_dt        = gbm_dt_q;
    assign price_valid   = price_valid_q;
    assign price         = price_q;
    assign step_idx      = step_idx_q;
    assign path_idx      = path_idx_q;
    assign path_last     = path_last_q;

    // Next-state and register-load decisions for the one-step-in-flight walk
    always_comb begin
        state_d       = state_q;
        s_cur_d       = s_cur_q;
        step_d        = step_q;
        gbm_z_d       = gbm_z_q;
        gbm_s_d       = gbm_s_q;
        gbm_r_d       = gbm_r_q;
        gbm_sigma_d   = gbm_sigma_q;
        gbm_dt_d      = gbm_dt_q;
        price_d       = price_q;
        step_idx_d    = step_idx_q;
        path_idx_d    = path_idx_q;
        path_last_d   = path_last_q;
        price_valid_d = price_valid_q;
        case (state_q)
            IDLE: if (start_valid) begin
                s_cur_d = S0;
                step_d  = '0;
                state_d = FETCH;
            end
            FETCH: if (z_valid) begin
                gbm_z_d     = z;
                gbm_s_d     = s_cur_q;
                gbm_r_d     = r;
                gbm_sigma_d = sigma;
                gbm_dt_d    = dt;
                state_d     = ISSUE;
            end
            ISSUE: if (gbm_ready) state_d = WAIT;
            WAIT: if (gbm_res_valid) begin
                s_cur_d       = s_clamped;
                step_d        = step_next;
                price_d       = s_clamped;
                step_idx_d    = step_next;
                path_last_d   = (step_next == STEP_W'(N_STEPS));
                price_valid_d = 1'b1;
                state_d       = EMIT;
            end
            EMIT: if (price_ready) begin
                price_valid_d = 1'b0;
                if (step_q == STEP_W'(N_STEPS)) begin
                    path_idx_d = path_idx_q + 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears the whole lane at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            s_cur_q       <= '0;
            step_q        <= '0;
            gbm_z_q       <= '0;
            gbm_s_q       <= '0;
            gbm_r_q       <= '0;
            gbm_sigma_q   <= '0;
            gbm_dt_q      <= '0;
            price_q       <= '0;
            step_idx_q    <= '0;
            path_idx_q    <= '0;
            path_last_q   <= 1'b0;
            price_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_cur_q       <= s_cur_d;
            step_q        <= step_d;
            gbm_z_q       <= gbm_z_d;
            gbm_s_q       <= gbm_s_d;
            gbm_r_q       <= gbm_r_d;
            gbm_sigma_q   <= gbm_sigma_d;
            gbm_dt_q      <= gbm_dt_d;
            price_q       <= price_d;
            step_idx_q    <= step_idx_d;
            path_idx_q    <= path_idx_d;
            path_last_q   <= path_last_d;
            price_valid_q <= price_valid_d;
        end
    end

`ifndef SYNTHESIS
    logic outstanding_q, outstanding_d;

    // Tracks whether a GBM request has been issued but its result not yet taken
    always_comb begin
        outstanding_d = outstanding_q;
        if (gbm_valid && gbm_ready) outstanding_d = 1'b1;
        else if (gbm_res_valid && gbm_res_ready) outstanding_d = 1'b0;
    end

    // Outstanding-request flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) outstanding_q <= 1'b0;
        else outstanding_q <= outstanding_d;
    end

    a_price_stable: assert property (@(posedge clk) disable iff (!rst_n)
        price_valid && !price_ready |=> price_valid && $stable(price) && $stable(step_idx) && $stable(path_idx));
    a_one_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        !(gbm_valid && gbm_ready && outstanding_q));
    a_no_unsolicited: assert property (@(posedge clk) disable iff (!rst_n)
        gbm_res_valid |-> state_q == WAIT);
`endif

endmodule

// File: tb/tb_gbm_path_sequencer.sv
// tb_gbm_path_sequencer: directed checks of the path sequencer against a 3-cycle S+z GBM stub
module tb_gbm_path_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] S0 = '0;
    logic [31:0] r = 32'h0000_0CCD;
    logic [31:0] sigma = 32'h0000_3333;
    logic [31:0] dt = 32'h0000_0400;
    logic        z_valid = 1'b0;
    logic        z_ready;
    logic [31:0] z = '0;
    logic        gbm_valid;
    logic        gbm_ready;
    logic [31:0] gbm_z, gbm_S, gbm_r, gbm_sigma, gbm_dt;
    logic        gbm_res_valid;
    logic        gbm_res_ready;
    logic [31:0] gbm_S_next;
    logic        price_valid;
    logic        price_ready = 1'b0;
    logic [31:0] price;
    logic [2:0]  step_idx;
    logic [15:0] path_idx;
    logic        path_last;
    logic        busy;

    logic        gbm_ready_en = 1'b1;
    logic        stub_busy;
    logic [1:0]  stub_cnt;
    int          z_xfers = 0;
    int          checks = 0;
    int          errors = 0;

    gbm_path_sequencer #(.WIDTH(32), .QFRAC(16), .N_STEPS(4), .PATH_W(16), .LANE_ID(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready), .S0(S0),
        .r(r), .sigma(sigma), .dt(dt),
        .z_valid(z_valid), .z_ready(z_ready), .z(z),
        .gbm_valid(gbm_valid), .gbm_ready(gbm_ready),
        .gbm_z(gbm_z), .gbm_S(gbm_S), .gbm_r(gbm_r), .gbm_sigma(gbm_sigma), .gbm_dt(gbm_dt),
        .gbm_res_valid(gbm_res_valid), .gbm_res_ready(gbm_res_ready), .gbm_S_next(gbm_S_next),
        .price_valid(price_valid), .price_ready(price_ready), .price(price),
        .step_idx(step_idx), .path_idx(path_idx), .path_last(path_last), .busy(busy)
    );

    always #5 clk = ~clk;

    assign gbm_ready = !stub_busy && gbm_ready_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy     <= 1'b0;
            stub_cnt      <= '0;
            gbm_res_valid <= 1'b0;
            gbm_S_next    <= '0;
        end else if (!stub_busy) begin
            if (gbm_valid && gbm_ready) begin
                stub_busy  <= 1'b1;
                stub_cnt   <= 2'd2;
                gbm_S_next <= gbm_S + gbm_z;
            end
        end else if (gbm_res_valid) begin
            if (gbm_res_ready) begin
                gbm_res_valid <= 1'b0;
                stub_busy     <= 1'b0;
            end
        end else if (stub_cnt == 0) begin
            gbm_res_valid <= 1'b1;
        end else begin
            stub_cnt <= stub_cnt - 1'b1;
        end
    end

    always @(posedge clk) if (rst_n && z_valid && z_ready) z_xfers <= z_xfers + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_price(input string tag);
        int n = 0;
        while (price_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, price_valid}, 32'd1);
    endtask

    task automatic accept_price();
        price_ready = 1'b1;
        tick();
        price_ready = 1'b0;
    endtask

    task automatic give_z(input logic [31:0] v);
        int n = 0;
        logic bad = 1'b0;
        while (z_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        repeat (5) begin
            tick();
            bad |= (z_ready !== 1'b1) || (gbm_valid !== 1'b0);
        end
        chk("z_gap_hold", {31'b0, bad}, 32'd0);
        z = v;
        z_valid = 1'b1;
        tick();
        z_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_p1 [4] = '{32'h0065_0000, 32'h0066_0000, 32'h0067_0000, 32'h0068_0000};
        logic [31:0] zv2    [4] = '{32'hFFFE_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        logic [31:0] exp_p2 [4] = '{32'h0000_0001, 32'h0001_0001, 32'h0002_0001, 32'h0003_0001};
        int z_base;
        logic bad;

        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_start_ready", {31'b0, start_ready}, 32'd1);
        chk("rst_valids", {29'b0, price_valid, gbm_valid, z_ready}, 32'd0);
        chk("rst_res_ready", {31'b0, gbm_res_ready}, 32'd0);
        chk("rst_price", price, 32'd0);
        chk("rst_gbm_S", gbm_S, 32'd0);
        chk("rst_idx", {13'b0, step_idx, path_idx}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // path 0: S0=100.0, z=+1.0 each step, backpressure on step 2
        S0 = 32'h0064_0000;
        z = 32'h0001_0000;
        z_valid = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        chk("p0_fetch_z_ready", {30'b0, z_ready, busy}, 32'd3);
        tick();
        chk("p0_issue_valid", {31'b0, gbm_valid}, 32'd1);
        chk("p0_issue_S", gbm_S, 32'h0064_0000);
        chk("p0_issue_z", gbm_z, 32'h0001_0000);
        chk("p0_issue_r", gbm_r, 32'h0000_0CCD);
        chk("p0_issue_sigma", gbm_sigma, 32'h0000_3333);
        chk("p0_issue_dt", gbm_dt, 32'h0000_0400);
        for (int k = 0; k < 4; k++) begin
            wait_price("p0_price_valid");
            chk("p0_price", price, exp_p1[k]);
            chk("p0_step_idx", {29'b0, step_idx}, k + 1);
            chk("p0_path_last", {31'b0, path_last}, (k == 3) ? 32'd1 : 32'd0);
            chk("p0_path_idx", {16'b0, path_idx}, 32'd0);
            if (k == 1) begin
                bad = 1'b0;
                repeat (10) begin
                    tick();
                    bad |= (price_valid !== 1'b1) || (price !== 32'h0066_0000) || (step_idx !== 3'd2)
                         || (gbm_valid !== 1'b0) || (z_ready !== 1'b0);
                end
                chk("p0_backpressure_hold", {31'b0, bad}, 32'd0);
            end
            accept_price();
        end
        chk("p0_done_path_idx", {16'b0, path_idx}, 32'd1);
        chk("p0_done_idle", {30'b0, busy, start_ready}, 32'd1);

        // path 1: clamp, z gaps, GBM stall, start pulse while busy
        z_valid = 1'b0;
        z_base = z_xfers;
        S0 = 32'h0001_0000;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                S0 = 32'h0050_0000;
                start_valid = 1'b1;
                chk("p1_start_ready_busy", {31'b0, start_ready}, 32'd0);
                tick();
                start_valid = 1'b0;
                chk("p1_still_busy", {31'b0, busy}, 32'd1);
            end
            if (k == 2) gbm_ready_en = 1'b0;
            give_z(zv2[k]);
            if (k == 1) chk("p1_clamped_gbm_S", gbm_S, 32'h0000_0001);
            if (k == 2) begin
                bad = 1'b0;
                repeat (7) begin
                    tick();
                    bad |= (gbm_valid !== 1'b1) || (gbm_S !== 32'h0001_0001) || (z_ready !== 1'b0);
                end
                chk("p1_gbm_stall_hold", {31'b0, bad}, 32'd0);
                gbm_ready_en = 1'b1;
            end
            wait_price("p1_price_valid");
            chk("p1_price", price, exp_p2[k]);
            chk("p1_step_idx", {29'b0, step_idx}, k + 1);
            chk("p1_path_last", {31'b0, path_last}, (k == 3) ? 32'd1 : 32'd0);
            chk("p1_path_idx", {16'b0, path_idx}, 32'd1);
            accept_price();
        end
        chk("p1_start_ready_after", {31'b0, start_ready}, 32'd1);
        chk("p1_done_path_idx", {16'b0, path_idx}, 32'd2);
        chk("p1_z_xfers", z_xfers - z_base, 32'd4);

        // path 2: start one cycle after the final EMIT, then reset while waiting on GBM
        S0 = 32'h00C8_0000;
        z = 32'h0001_0000;
        z_valid = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        chk("p2_accepted", {30'b0, busy, start_ready}, 32'd2);
        for (int n = 0; n < 40 && gbm_res_ready !== 1'b1; n++) tick();
        chk("p2_in_wait", {31'b0, gbm_res_ready}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_valids", {28'b0, price_valid, gbm_valid, z_ready, gbm_res_ready}, 32'd0);
        chk("mid_rst_price", price, 32'd0);
        chk("mid_rst_gbm_S", gbm_S, 32'd0);
        chk("mid_rst_idx", {13'b0, step_idx, path_idx}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // path after reset restarts at path 0, step 1
        S0 = 32'h0064_0000;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        wait_price("p3_price_valid");
        chk("p3_price", price, 32'h0065_0000);
        chk("p3_step_idx", {29'b0, step_idx}, 32'd1);
        chk("p3_path_idx", {16'b0, path_idx}, 32'd0);
        accept_price();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
